// File: rtl/word_breaker.sv
// Pops 32-bit words from the FIFO read side and streams them out as byte chunks
// on a valid/ready interface, absorbing the FIFO's one-cycle registered read latency.
module word_breaker #(
    parameter int WORD_SIZE = 32,
    parameter int BYTE_SIZE = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 fifo_empty,
    output logic                 fifo_rd_en,
    input  logic [WORD_SIZE-1:0] fifo_data,
    output logic                 byte_valid,
    input  logic                 byte_ready,
    output logic [BYTE_SIZE-1:0] byte_data,
    output logic                 byte_last,
    output logic                 busy
);

    localparam int NUM_BYTES = WORD_SIZE / BYTE_SIZE;
    localparam int IDX_W     = (NUM_BYTES < 2) ? 1 : $clog2(NUM_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    if ((WORD_SIZE % BYTE_SIZE) != 0 || NUM_BYTES < 2) begin : g_bad_params
        $error("word_breaker: WORD_SIZE must be a multiple of BYTE_SIZE with at least two chunks");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WORD_SIZE-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]     idx_q,   idx_d;
    logic [BYTE_SIZE-1:0] chunk;

    // The chunk on the wire always sits at the end of the register that shifts out first.
    assign chunk = MSB_FIRST ? shift_q[WORD_SIZE-1 -: BYTE_SIZE] : shift_q[BYTE_SIZE-1:0];

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        idx_d      = idx_q;
        fifo_rd_en = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty && !reset) begin
                    fifo_rd_en = 1'b1;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                shift_d = fifo_data;
                idx_d   = '0;
                state_d = SEND;
            end
            SEND: begin
                if (byte_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                    end else begin
                        shift_d = MSB_FIRST ? (shift_q << BYTE_SIZE) : (shift_q >> BYTE_SIZE);
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
        end
    end

    // Stream outputs depend on registered state only, never on byte_ready.
    assign byte_valid = (state_q == SEND);
    assign byte_data  = byte_valid ? chunk : '0;
    assign byte_last  = byte_valid && (idx_q == LAST_IDX);
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_word_breaker.sv
// Directed self-checking bench for word_breaker: a small FIFO model feeds an
// LSB-first instance, and a second MSB-first instance checks the reversed order.
module tb_word_breaker;

    logic        clock;
    logic        reset;
    logic        byte_ready;

    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [31:0] fifo_data;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_last;
    logic        busy;

    logic        m_empty;
    logic        m_rd_en;
    logic [31:0] m_data;
    logic        m_valid;
    logic [7:0]  m_byte;
    logic        m_last;
    logic        m_busy;
    logic        m_arm;

    logic [31:0] mem [0:63];
    int          wr_ptr;
    int          rd_ptr;
    logic [31:0] stage_q [$];

    int          checks;
    int          errors;

    word_breaker #(.WORD_SIZE(32), .BYTE_SIZE(8), .MSB_FIRST(1'b0)) dut (
        .clock      (clock),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_data  (fifo_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .byte_data  (byte_data),
        .byte_last  (byte_last),
        .busy       (busy)
    );

    word_breaker #(.WORD_SIZE(32), .BYTE_SIZE(8), .MSB_FIRST(1'b1)) dut_msb (
        .clock      (clock),
        .reset      (reset),
        .fifo_empty (m_empty),
        .fifo_rd_en (m_rd_en),
        .fifo_data  (m_data),
        .byte_valid (m_valid),
        .byte_ready (byte_ready),
        .byte_data  (m_byte),
        .byte_last  (m_last),
        .busy       (m_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // FIFO model with the registered one-cycle read latency of the block RAM.
    assign fifo_empty = (rd_ptr == wr_ptr);
    always @(posedge clock) begin
        if (fifo_rd_en && (rd_ptr != wr_ptr)) begin
            fifo_data <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    assign m_data = 32'h44332211;
    always @(posedge clock) begin
        if (m_rd_en) m_empty <= 1'b1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic pushWord(input logic [31:0] w);
        stage_q.push_back(w);
    endtask

    // Drive one cycle's inputs at the falling edge, then let outputs settle before checks.
    task automatic applyStimulus(input logic rdy, input logic rst);
        @(negedge clock);
        reset      = rst;
        byte_ready = rdy;
        while (stage_q.size() > 0) begin
            mem[wr_ptr] = stage_q.pop_front();
            wr_ptr++;
        end
        if (m_arm) begin
            m_empty = 1'b0;
            m_arm   = 1'b0;
        end
        #2;
    endtask

    task automatic expectCycle(input string tag, input logic rd, input logic v,
                               input logic [7:0] d, input logic l, input logic b);
        checkOutput({tag, "_rd_en"}, 32'(fifo_rd_en), 32'(rd));
        checkOutput({tag, "_valid"}, 32'(byte_valid), 32'(v));
        checkOutput({tag, "_data"},  32'(byte_data),  32'(d));
        checkOutput({tag, "_last"},  32'(byte_last),  32'(l));
        checkOutput({tag, "_busy"},  32'(busy),       32'(b));
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] w2;
        checks     = 0;
        errors     = 0;
        wr_ptr     = 0;
        rd_ptr     = 0;
        reset      = 1'b1;
        byte_ready = 1'b0;
        m_empty    = 1'b1;
        m_arm      = 1'b0;
        fifo_data  = '0;

        // Reset state
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1);
        expectCycle("rst", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("rst_msb_busy", 32'(m_busy), 32'd0);

        // LSB-first and MSB-first serialisation of 0x44332211
        w = 32'h44332211;
        pushWord(w);
        m_arm = 1'b1;
        applyStimulus(1'b1, 1'b0);
        expectCycle("t1_c0", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("t1_msb_rd_en", 32'(m_rd_en), 32'd1);
        applyStimulus(1'b1, 1'b0);
        expectCycle("t1_c1", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0);
            expectCycle($sformatf("t1_b%0d", i), 1'b0, 1'b1, w[8*i +: 8], (i == 3), 1'b1);
            checkOutput($sformatf("t1_msb_valid%0d", i), 32'(m_valid), 32'd1);
            checkOutput($sformatf("t1_msb_data%0d", i), 32'(m_byte), 32'(w[8*(3-i) +: 8]));
            checkOutput($sformatf("t1_msb_last%0d", i), 32'(m_last), 32'(i == 3));
        end
        applyStimulus(1'b1, 1'b0);
        expectCycle("t1_done", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("t1_msb_busy", 32'(m_busy), 32'd0);

        // Backpressure while 0xC3 is on the wire
        pushWord(32'hA1B2C3D4);
        applyStimulus(1'b1, 1'b0);
        expectCycle("t3_c0", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        expectCycle("t3_c1", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0);
        expectCycle("t3_d4", 1'b0, 1'b1, 8'hD4, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0);
            expectCycle($sformatf("t3_hold%0d", i), 1'b0, 1'b1, 8'hC3, 1'b0, 1'b1);
        end
        applyStimulus(1'b1, 1'b0);
        expectCycle("t3_c3", 1'b0, 1'b1, 8'hC3, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0);
        expectCycle("t3_b2", 1'b0, 1'b1, 8'hB2, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0);
        expectCycle("t3_a1", 1'b0, 1'b1, 8'hA1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0);
        expectCycle("t3_done", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        // Two back-to-back words
        w  = 32'hA1B2C3D4;
        w2 = 32'h01020304;
        pushWord(w);
        pushWord(w2);
        applyStimulus(1'b1, 1'b0);
        expectCycle("t4_c0", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        expectCycle("t4_c1", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0);
            expectCycle($sformatf("t4_w0b%0d", i), 1'b0, 1'b1, w[8*i +: 8], (i == 3), 1'b1);
        end
        applyStimulus(1'b1, 1'b0);
        expectCycle("t4_gap0", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        expectCycle("t4_gap1", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0);
            expectCycle($sformatf("t4_w1b%0d", i), 1'b0, 1'b1, w2[8*i +: 8], (i == 3), 1'b1);
        end
        applyStimulus(1'b1, 1'b0);
        expectCycle("t4_done", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        // Empty FIFO for 20 cycles
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 1'b0);
            expectCycle($sformatf("t5_c%0d", i), 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        end

        // Reset mid-word discards the remaining chunks
        pushWord(32'h44332211);
        applyStimulus(1'b1, 1'b0);
        expectCycle("t6_c0", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        expectCycle("t6_c1", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0);
        expectCycle("t6_11", 1'b0, 1'b1, 8'h11, 1'b0, 1'b1);
        w = 32'h55667788;
        pushWord(w);
        applyStimulus(1'b1, 1'b1);
        expectCycle("t6_rst", 1'b0, 1'b1, 8'h22, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0);
        expectCycle("t6_after", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        expectCycle("t6_wait", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0);
            expectCycle($sformatf("t6_b%0d", i), 1'b0, 1'b1, w[8*i +: 8], (i == 3), 1'b1);
        end
        applyStimulus(1'b1, 1'b0);
        expectCycle("t6_done", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        // Reset gates the pop request and aborts a word waiting on read data
        pushWord(32'hCAFEF00D);
        applyStimulus(1'b1, 1'b1);
        expectCycle("t7_rst_idle", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        expectCycle("t7_pop", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1);
        expectCycle("t7_rst_wait", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0);
        expectCycle("t7_done", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
